// File: rtl/frv_ex_result_buf_if.sv
// rtl/frv_ex_result_buf_if.sv - execute-to-memory result buffer port bundle
// slave: the buffer's view; master: the surrounding pipeline's view.
interface frv_ex_result_buf_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            i_ready;
  logic            i_flush;
  logic [XLEN-1:0] i_result;
  logic [4:0]      i_rd;
  logic            i_wen;
  logic            o_valid;
  logic            o_ready;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd;
  logic            o_wen;
  logic [4:0]      fwd_rs;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  modport slave (
    input  i_valid, i_flush, i_result, i_rd, i_wen, o_ready, fwd_rs,
    output i_ready, o_valid, o_result, o_rd, o_wen, fwd_hit, fwd_data
  );

  modport master (
    output i_valid, i_flush, i_result, i_rd, i_wen, o_ready, fwd_rs,
    input  i_ready, o_valid, o_result, o_rd, o_wen, fwd_hit, fwd_data
  );
endinterface

// File: rtl/frv_ex_result_buf.sv
// rtl/frv_ex_result_buf.sv - execute-to-memory result buffer with decode forwarding
// Build option FRV_EX_SKID_EN adds a skid entry and a registered i_ready.
module frv_ex_result_buf #(
  parameter int XLEN = 32
) (
  input logic                g_clk,
  input logic                g_resetn,
  frv_ex_result_buf_if.slave bus
);
  localparam int XL = XLEN - 1;

`ifdef FRV_EX_SKID_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;
`endif

  state_t     state_q;
  state_t     state_d;

  logic       in_fire;
  logic       out_fire;
  logic       load_head_in;

  logic [XL:0] head_result;
  logic [4:0]  head_rd;
  logic        head_wen;
  logic        head_match;

  logic        hit_c;
  logic [XL:0] data_c;

`ifdef FRV_EX_SKID_EN
  logic        load_head_skid;
  logic        load_skid;
  logic [XL:0] skid_result;
  logic [4:0]  skid_rd;
  logic        skid_wen;
  logic        skid_match;

  // Decoded straight from the state register, so o_ready never reaches i_ready.
  assign bus.i_ready = (state_q != S_TWO);
`else
  assign bus.i_ready = (state_q == S_EMPTY) || bus.o_ready;
`endif

  assign bus.o_valid = (state_q != S_EMPTY);
  assign in_fire     = bus.i_valid && bus.i_ready;
  assign out_fire    = bus.o_valid && bus.o_ready;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_head_in = 1'b0;
`ifdef FRV_EX_SKID_EN
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
`endif
    if (bus.i_flush) begin
      // Flush wins over both transfers; the incoming result is dropped.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
`ifdef FRV_EX_SKID_EN
        S_EMPTY: begin
          if (in_fire) begin
            state_d      = S_ONE;
            load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            load_head_in = 1'b1;
          end else if (in_fire) begin
            state_d   = S_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d        = S_ONE;
            load_head_skid = 1'b1;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
`else
        S_EMPTY: begin
          if (in_fire) begin
            state_d      = S_FULL;
            load_head_in = 1'b1;
          end
        end
        S_FULL: begin
          if (in_fire) begin
            load_head_in = 1'b1;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
`endif
      endcase
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      head_result <= '0;
      head_rd     <= 5'd0;
      head_wen    <= 1'b0;
    end else if (load_head_in) begin
      head_result <= bus.i_result;
      head_rd     <= bus.i_rd;
      head_wen    <= bus.i_wen;
`ifdef FRV_EX_SKID_EN
    end else if (load_head_skid) begin
      head_result <= skid_result;
      head_rd     <= skid_rd;
      head_wen    <= skid_wen;
`endif
    end
  end

`ifdef FRV_EX_SKID_EN
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      skid_result <= '0;
      skid_rd     <= 5'd0;
      skid_wen    <= 1'b0;
    end else if (load_skid) begin
      skid_result <= bus.i_result;
      skid_rd     <= bus.i_rd;
      skid_wen    <= bus.i_wen;
    end
  end
`endif

  assign bus.o_result = head_result;
  assign bus.o_rd     = head_rd;
  assign bus.o_wen    = head_wen;

  // x0 is hardwired zero, so it never forwards.
  assign head_match = bus.o_valid && head_wen && (head_rd == bus.fwd_rs) &&
                      (bus.fwd_rs != 5'd0);
`ifdef FRV_EX_SKID_EN
  assign skid_match = (state_q == S_TWO) && skid_wen && (skid_rd == bus.fwd_rs) &&
                      (bus.fwd_rs != 5'd0);
`endif

  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
`ifdef FRV_EX_SKID_EN
    if (skid_match) begin
      hit_c  = 1'b1;
      data_c = skid_result;
    end else if (head_match) begin
      hit_c  = 1'b1;
      data_c = head_result;
    end
`else
    if (head_match) begin
      hit_c  = 1'b1;
      data_c = head_result;
    end
`endif
  end

  assign bus.fwd_hit  = hit_c;
  assign bus.fwd_data = data_c;

endmodule

// File: tb/tb_frv_ex_result_buf.sv
// tb/tb_frv_ex_result_buf.sv - self-checking bench for frv_ex_result_buf
// Queue-based reference model; honours FRV_EX_SKID_EN like the design.
module tb_frv_ex_result_buf;
`ifdef FRV_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  logic g_clk;
  logic g_resetn;
  int   n_checks;
  int   n_err;
  ent_t mq[$];
  ent_t got[$];
  ent_t pend[$];
  logic acc;

  frv_ex_result_buf_if #(.XLEN(32)) bus ();

  frv_ex_result_buf #(.XLEN(32)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic ordy);
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || ordy;
  endfunction

  // One clock: drive, check against the model at negedge, advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] r, input logic [4:0] rd,
                      input logic w, input logic ordy, input logic fl,
                      input logic [4:0] frs, output logic accepted);
    logic        exp_ready;
    logic        exp_valid;
    logic        hit_e;
    logic [31:0] data_e;
    ent_t        e;
    bus.i_valid  = v;
    bus.i_result = r;
    bus.i_rd     = rd;
    bus.i_wen    = w;
    bus.o_ready  = ordy;
    bus.i_flush  = fl;
    bus.fwd_rs   = frs;
    @(negedge g_clk);
    exp_ready = model_ready(ordy);
    exp_valid = (mq.size() != 0);
    chk("i_ready", bus.i_ready, exp_ready);
    chk("o_valid", bus.o_valid, exp_valid);
    if (exp_valid) begin
      chk("o_result", bus.o_result, mq[0].r);
      chk("o_rd", bus.o_rd, mq[0].rd);
      chk("o_wen", bus.o_wen, mq[0].wen);
    end
    hit_e  = 1'b0;
    data_e = 32'd0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].wen && mq[i].rd == frs && frs != 5'd0) begin
        hit_e  = 1'b1;
        data_e = mq[i].r;
      end
    end
    chk("fwd_hit", bus.fwd_hit, hit_e);
    chk("fwd_data", bus.fwd_data, data_e);
    @(posedge g_clk);
    accepted = v && exp_ready;
    if (exp_valid && ordy) got.push_back(mq[0]);
    if (fl) begin
      mq.delete();
    end else begin
      if (exp_valid && ordy) void'(mq.pop_front());
      if (v && exp_ready) begin
        e.r = r; e.rd = rd; e.wen = w;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 5'd0, 1'b0, ordy, 1'b0, 5'd0, acc);
  endtask

  initial begin
    ent_t e;
    int   bound;
    n_checks = 0;
    n_err    = 0;
    g_resetn = 1'b0;
    bus.i_valid = 1'b0; bus.i_result = 32'd0; bus.i_rd = 5'd0; bus.i_wen = 1'b0;
    bus.o_ready = 1'b0; bus.i_flush = 1'b0; bus.fwd_rs = 5'd5;

    // Reset state
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    #1;
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_i_ready", bus.i_ready, 1'b1);
    chk("rst_o_result", bus.o_result, 32'h0);
    chk("rst_o_rd", bus.o_rd, 5'd0);
    chk("rst_o_wen", bus.o_wen, 1'b0);
    chk("rst_fwd_hit", bus.fwd_hit, 1'b0);
    @(posedge g_clk);
    #1;

    // Streaming at full rate
    step(1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 1'b0, 5'd1, acc);
    chk("stream_0", bus.o_result, 32'h11);
    chk("stream_rdy0", bus.i_ready, 1'b1);
    step(1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, acc);
    chk("stream_1", bus.o_result, 32'h22);
    chk("stream_rdy1", bus.i_ready, 1'b1);
    step(1'b1, 32'h33, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, acc);
    chk("stream_2", bus.o_result, 32'h33);
    chk("stream_rdy2", bus.i_ready, 1'b1);
    idle(1'b1);
    chk("stream_drained", bus.o_valid, 1'b0);

    // Back-pressure: producer holds each value until accepted
    pend.delete();
    e.r = 32'hA; e.rd = 5'd5; e.wen = 1'b1; pend.push_back(e);
    e.r = 32'hB; e.rd = 5'd6; e.wen = 1'b1; pend.push_back(e);
    e.r = 32'hC; e.rd = 5'd7; e.wen = 1'b1; pend.push_back(e);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, pend[0].r, pend[0].rd, pend[0].wen, 1'b0, 1'b0, 5'd6, acc);
      if (acc) void'(pend.pop_front());
    end
    chk("bp_ready_low", bus.i_ready, 1'b0);
    chk("bp_pending", pend.size(), 3 - CAP);
    got.delete();
    bound = 0;
    while ((pend.size() != 0 || mq.size() != 0) && bound < 20) begin
      if (pend.size() != 0) begin
        step(1'b1, pend[0].r, pend[0].rd, pend[0].wen, 1'b1, 1'b0, 5'd5, acc);
        if (acc) void'(pend.pop_front());
      end else begin
        idle(1'b1);
      end
      bound++;
    end
    chk("bp_bound", bound < 20, 1'b1);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0].r, 32'hA);
      chk("bp_order1", got[1].r, 32'hB);
      chk("bp_order2", got[2].r, 32'hC);
    end

    // Forwarding: youngest matching entry wins, x0 never hits, wen=0 never hits
    step(1'b1, 32'h100, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, acc);
    step(1'b1, 32'h200, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, acc);
    bus.fwd_rs = 5'd7;
    #1;
    chk("fwd_hit_7", bus.fwd_hit, 1'b1);
    chk("fwd_data_7", bus.fwd_data, (CAP == 2) ? 32'h200 : 32'h100);
    bus.fwd_rs = 5'd0;
    #1;
    chk("fwd_hit_x0", bus.fwd_hit, 1'b0);
    chk("fwd_data_x0", bus.fwd_data, 32'h0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, acc);
    step(1'b1, 32'h300, 5'd9, 1'b0, 1'b0, 1'b0, 5'd9, acc);
    bus.fwd_rs = 5'd9;
    #1;
    chk("fwd_nowen_hit", bus.fwd_hit, 1'b0);
    chk("fwd_nowen_data", bus.fwd_data, 32'h0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, acc);

    // Flush while full, together with an offered input
    for (int k = 0; k < CAP; k++)
      step(1'b1, 32'h40 + k, 5'd4, 1'b1, 1'b0, 1'b0, 5'd4, acc);
    step(1'b1, 32'hDEAD, 5'd4, 1'b1, 1'b0, 1'b1, 5'd4, acc);
    chk("flush_o_valid", bus.o_valid, 1'b0);
    chk("flush_i_ready", bus.i_ready, 1'b1);
    got.delete();
    repeat (2) idle(1'b1);
    chk("flush_no_leak", got.size(), 0);

    // Asynchronous reset between edges with the buffer full
    for (int k = 0; k < CAP; k++)
      step(1'b1, 32'h50 + k, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, acc);
    chk("arst_pre_valid", bus.o_valid, 1'b1);
    #3;
    g_resetn = 1'b0;
    #1;
    chk("arst_o_valid", bus.o_valid, 1'b0);
    chk("arst_i_ready", bus.i_ready, 1'b1);
    chk("arst_o_result", bus.o_result, 32'h0);
    chk("arst_fwd_hit", bus.fwd_hit, 1'b0);
    mq.delete();
    #1;
    g_resetn = 1'b1;
    idle(1'b0);
    idle(1'b1);

    // Randomized traffic against the model
    e.r = $urandom; e.rd = 5'($urandom_range(0, 7)); e.wen = 1'($urandom);
    for (int n = 0; n < 500; n++) begin
      step(1'($urandom_range(0, 3) != 0), e.r, e.rd, e.wen,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
           5'($urandom_range(0, 7)), acc);
      if (acc || bus.i_valid == 1'b0) begin
        e.r = $urandom; e.rd = 5'($urandom_range(0, 7)); e.wen = 1'($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/frv_ex_result_buf.md
# frv_ex_result_buf

Execute-to-memory result buffer. Sits directly downstream of the execute-stage ALU and captures each completed ALU result with its destination register tag. Decouples the execute stage from memory-stage back-pressure using a valid/ready handshake. Also serves as a register-forwarding source for the decode stage.

## Interface
Parameters:
- XLEN, 32, datapath width; XL = XLEN-1.

Ports:
- g_clk  in  1  global clock, rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- i_valid  in  1  execute stage presents a result.
- i_ready  out  1  buffer can accept this cycle.
- i_flush  in  1  discard all buffered entries.
- i_result  in  XLEN  ALU result.
- i_rd  in  5  destination register.
- i_wen  in  1  result is written back.
- o_valid  out  1  head entry valid.
- o_ready  in  1  memory stage accepts head.
- o_result  out  XLEN  head result.
- o_rd  out  5  head destination.
- o_wen  out  1  head write enable.
- fwd_rs  in  5  register queried by decode.
- fwd_hit  out  1  a buffered entry writes fwd_rs.
- fwd_data  out  XLEN  youngest matching result.

## Operation
- Input transfer: i_valid && i_ready at a rising edge. Output transfer: o_valid && o_ready at a rising edge.
- Storage: head register (drives o_*) plus, with FRV_EX_SKID_EN, one skid register.
- States (skid build): EMPTY, ONE (head only), TWO (head + skid).
  - EMPTY + in -> ONE, input loads head.
  - ONE + in + out -> ONE, input loads head.
  - ONE + in, no out -> TWO, input loads skid.
  - ONE + out, no in -> EMPTY.
  - TWO + out -> ONE, skid moves to head. No input is possible because i_ready = 0.
- i_ready = (state != TWO). It is registered and has no combinational path from o_ready.
- Flush: at the edge where i_flush = 1, the state goes to EMPTY. Flush takes priority over a simultaneous input or output transfer. The input is dropped and o_valid is 0 the next cycle. A transfer in the flush cycle still completes from the consumer's view, because o_* are valid until that edge.
- Forwarding is combinational from stored state only:
  - An entry matches when it is valid, its wen = 1, its rd == fwd_rs, and fwd_rs != 0.
  - The skid entry is younger than the head. If both match, fwd_data is the skid result.
  - With no match, fwd_hit = 0 and fwd_data = 0.
- Data registers load only on accepted input or a skid-to-head move. Otherwise they hold their value.

## Timing
- Reset values: o_valid 0, o_result 0, o_rd 0, o_wen 0, skid cleared, state EMPTY, i_ready 1, fwd_hit 0.
- Latency: an input accepted at edge N appears on o_* during cycle N+1.
- Throughput: 1 entry per cycle while o_ready = 1.
- With o_ready = 0, the buffer absorbs exactly 2 inputs (skid build), then deasserts i_ready.
- A reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Buffered entries are lost.
- o_* are stable while o_valid && !o_ready, unless i_flush is asserted.

## Configuration
- FRV_EX_SKID_EN defined: two-entry skid build as above, with registered i_ready.
- FRV_EX_SKID_EN undefined: head register only, with states EMPTY/FULL.
  - i_ready = !o_valid || o_ready, a combinational path from o_ready.
  - Full throughput is kept, but a stalled buffer holds only 1 entry.
  - Forwarding checks the head only.
  - Flush and reset behaviour are unchanged.

## Test plan
- Reset: after g_resetn deassert -> o_valid 0, i_ready 1, o_result 0x00000000.
- Streaming: o_ready = 1; inputs 0x11, 0x22, 0x33 on consecutive cycles -> o_result shows 0x11, 0x22, 0x33 on the next three cycles, and i_ready stays 1.
- Back-pressure: o_ready = 0; offer rd=5 0xA, then rd=6 0xB, then 0xC.
  - Skid build: i_ready falls after the 2nd accept and 0xC is held off.
  - Release o_ready -> outputs 0xA, 0xB, 0xC in order with no loss.
  - Non-skid build: only 0xA is buffered.
- Forwarding: head rd=7 0x100 and skid rd=7 0x200, both with wen=1; fwd_rs=7 -> fwd_hit 1, fwd_data 0x200. fwd_rs=0 -> fwd_hit 0. An entry with wen=0 -> no hit.
- Flush: state TWO, assert i_flush together with i_valid -> next cycle o_valid 0, i_ready 1, and the flushed-cycle input never appears.
- Async reset mid-stall: pulse g_resetn low between edges with 2 entries held -> o_valid drops immediately, and state is EMPTY after release.
